dds_phase_accumulator: RTL and testbench

- Phase generator for the DDS chain; sits directly upstream of the sine lookup stage.
- Accumulates a frequency tuning word (FTW) every enabled cycle.
- Adds a programmable phase offset and presents the top OUT_W bits as the phase word that addresses the sine stage.
- Contains a linear frequency-sweep (chirp) engine that ramps the FTW from a base value to a limit.

---
 rtl/dds_phase_accumulator_if.sv | 38 +++
 rtl/dds_phase_accumulator.sv | 157 +++++++++++++++
 tb/tb_dds_phase_accumulator.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_phase_accumulator_if.sv
// Control/status bundle between the DDS controller and the phase accumulator.
// Latency: none; this is only a wire bundle.
// Backpressure: none; all signals are level or single-cycle pulses.
interface dds_phase_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 14
);
  // controller -> accumulator
  logic             en;
  logic [ACC_W-1:0] ftw_in;
  logic             ftw_load;
  logic [OUT_W-1:0] poff_in;
  logic             poff_load;
  logic             phase_clr;
  logic [ACC_W-1:0] sweep_step;
  logic [ACC_W-1:0] sweep_limit;
  logic             sweep_start;
  logic             sweep_abort;

  // accumulator -> sine stage / controller
  logic [OUT_W-1:0] phase_out;
  logic             phase_valid;
  logic             wrap;
  logic             sweeping;
  logic             sweep_done;

  modport master (
    output en, ftw_in, ftw_load, poff_in, poff_load, phase_clr,
           sweep_step, sweep_limit, sweep_start, sweep_abort,
    input  phase_out, phase_valid, wrap, sweeping, sweep_done
  );

  modport slave (
    input  en, ftw_in, ftw_load, poff_in, poff_load, phase_clr,
           sweep_step, sweep_limit, sweep_start, sweep_abort,
    output phase_out, phase_valid, wrap, sweeping, sweep_done
  );
endinterface

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator with phase offset and linear FTW sweep (chirp) engine.
// Latency: phase_out is registered and reflects the accumulator value of the previous cycle.
// Backpressure: none; en simply gates accumulation and sweep stepping.
module dds_phase_accumulator #(
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 14,
  parameter int SWEEP_WRAP = 0
) (
  input logic                    clk,
  input logic                    rst,
  dds_phase_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_reg;
  logic [ACC_W-1:0] ftw_nxt;
  logic [ACC_W-1:0] base_reg;
  logic [ACC_W-1:0] base_nxt;
  logic [OUT_W-1:0] poff_reg;
  logic [OUT_W-1:0] phase_q;
  logic             valid_q;
  logic             wrap_q;
  logic             done_q;
  logic             done_nxt;

  // One extra bit on both sums: carry for the wrap pulse, and an
  // unsigned compare against the limit that cannot alias on overflow.
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W:0]   sweep_sum;
  logic             limit_hit;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_reg};
  assign sweep_sum = {1'b0, ftw_reg} + {1'b0, bus.sweep_step};
  assign limit_hit = (sweep_sum >= {1'b0, bus.sweep_limit});

  // Phase accumulator; a clear overrides the add and suppresses wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      wrap_q <= 1'b0;
    end else if (bus.phase_clr) begin
      acc    <= '0;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      acc    <= acc_sum[ACC_W-1:0];
      wrap_q <= acc_sum[ACC_W];
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Output phase word from the pre-update accumulator plus offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        phase_q <= acc[ACC_W-1 -: OUT_W] + poff_reg;
      end
    end
  end

  // Phase offset register, writable in any sweep state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poff_reg <= '0;
    end else if (bus.poff_load) begin
      poff_reg <= bus.poff_in;
    end
  end

  // Sweep FSM state plus the tuning word / base registers it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FIXED;
      ftw_reg  <= '0;
      base_reg <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ftw_reg  <= ftw_nxt;
      base_reg <= base_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state logic. en only gates the per-cycle sweep step; start and
  // abort are control pulses and act whether or not en is high.
  always_comb begin
    state_nxt = state;
    ftw_nxt   = ftw_reg;
    base_nxt  = base_reg;
    done_nxt  = 1'b0;

    unique case (state)
      FIXED: begin
        if (bus.ftw_load) begin
          ftw_nxt = bus.ftw_in;
        end
        if (bus.sweep_start) begin
          // A same-cycle load becomes the sweep base as well.
          base_nxt  = bus.ftw_load ? bus.ftw_in : ftw_reg;
          state_nxt = SWEEP;
        end
      end

      SWEEP: begin
        if (bus.sweep_abort) begin
          state_nxt = FIXED;
        end else if (bus.en) begin
          if (limit_hit) begin
            done_nxt = 1'b1;
            if (SWEEP_WRAP != 0) begin
              ftw_nxt = base_reg;
            end else begin
              ftw_nxt   = bus.sweep_limit;
              state_nxt = HOLD;
            end
          end else begin
            ftw_nxt = sweep_sum[ACC_W-1:0];
          end
        end
      end

      HOLD: begin
        if (bus.sweep_abort) begin
          state_nxt = FIXED;
        end else if (bus.sweep_start) begin
          ftw_nxt   = base_reg;
          state_nxt = SWEEP;
        end
      end

      default: begin
        state_nxt = FIXED;
      end
    endcase
  end

  assign bus.phase_out   = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.sweeping    = (state == SWEEP);
  assign bus.sweep_done  = done_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator: clamp (dut0) and wrap (dut1) variants share stimulus.
// Accumulator ramps, wrap, offset and clear come from a vector table; sweep corners are hand sequences.
// Expected values are hand-computed constants.
module tb_dds_phase_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dds_phase_accumulator_if #(.ACC_W(24), .OUT_W(14)) b0 ();
  dds_phase_accumulator_if #(.ACC_W(24), .OUT_W(14)) b1 ();

  assign b1.en          = b0.en;
  assign b1.ftw_in      = b0.ftw_in;
  assign b1.ftw_load    = b0.ftw_load;
  assign b1.poff_in     = b0.poff_in;
  assign b1.poff_load   = b0.poff_load;
  assign b1.phase_clr   = b0.phase_clr;
  assign b1.sweep_step  = b0.sweep_step;
  assign b1.sweep_limit = b0.sweep_limit;
  assign b1.sweep_start = b0.sweep_start;
  assign b1.sweep_abort = b0.sweep_abort;

  dds_phase_accumulator #(.ACC_W(24), .OUT_W(14), .SWEEP_WRAP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  dds_phase_accumulator #(.ACC_W(24), .OUT_W(14), .SWEEP_WRAP(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        fl;
    logic [23:0] ftw;
    logic        pl;
    logic [13:0] poff;
    logic [13:0] e_po;
    logic        e_vld;
    logic        e_wrap;
    logic [23:0] e_acc;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.en          = 1'b0;
    b0.ftw_load    = 1'b0;
    b0.poff_load   = 1'b0;
    b0.phase_clr   = 1'b0;
    b0.sweep_start = 1'b0;
    b0.sweep_abort = 1'b0;
  endtask

  task automatic chk_sweep(input string nm, input logic [23:0] ftw0, input logic swp0,
                           input logic done0);
    chk({nm, "_ftw0"}, 32'(dut0.ftw_reg), 32'(ftw0));
    chk({nm, "_sweeping0"}, 32'(b0.sweeping), 32'(swp0));
    chk({nm, "_done0"}, 32'(b0.sweep_done), 32'(done0));
  endtask

  task automatic chk_sweep1(input string nm, input logic [23:0] ftw1, input logic swp1,
                            input logic done1);
    chk({nm, "_ftw1"}, 32'(dut1.ftw_reg), 32'(ftw1));
    chk({nm, "_sweeping1"}, 32'(b1.sweeping), 32'(swp1));
    chk({nm, "_done1"}, 32'(b1.sweep_done), 32'(done1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //           en clr fl  ftw          pl   poff     e_po      vld   wrap  e_acc
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 24'h000400, 1'b0, 14'h0000, 14'h0000, 1'b0, 1'b0, 24'h000000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 24'h000400};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0001, 1'b1, 1'b0, 24'h000800};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0002, 1'b1, 1'b0, 24'h000C00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0003, 1'b1, 1'b0, 24'h001000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 24'h400000, 1'b0, 14'h0000, 14'h0003, 1'b0, 1'b0, 24'h000000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 24'h400000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h1000, 1'b1, 1'b0, 24'h800000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h2000, 1'b1, 1'b0, 24'hC00000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3000, 1'b1, 1'b1, 24'h000000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 24'h400000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b0, 1'b0, 24'h400000};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 24'h000000, 1'b1, 14'h3FFF, 14'h0000, 1'b0, 1'b0, 24'h000000};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3FFF, 1'b1, 1'b0, 24'h000000};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 24'h000400, 1'b0, 14'h0000, 14'h3FFF, 1'b1, 1'b0, 24'h000000};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3FFF, 1'b1, 1'b0, 24'h000400};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 24'h000800};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0001, 1'b1, 1'b0, 24'h000C00};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0002, 1'b1, 1'b0, 24'h001000};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0003, 1'b1, 1'b0, 24'h001400};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0004, 1'b1, 1'b0, 24'h000000};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3FFF, 1'b1, 1'b0, 24'h000400};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 14'h0000, 14'h3FFF, 1'b0, 1'b0, 24'h000400};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 24'h000000};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3FFF, 1'b1, 1'b0, 24'hFFFFFF};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 14'h0000, 14'h3FFE, 1'b1, 1'b1, 24'hFFFFFE};

    // reset state
    rst            = 1'b1;
    idle();
    b0.ftw_in      = '0;
    b0.poff_in     = '0;
    b0.sweep_step  = '0;
    b0.sweep_limit = '0;
    #3;
    chk("rst_phase_out", 32'(b0.phase_out), 32'h0);
    chk("rst_phase_valid", 32'(b0.phase_valid), 32'h0);
    chk("rst_wrap", 32'(b0.wrap), 32'h0);
    chk("rst_sweeping", 32'(b0.sweeping), 32'h0);
    chk("rst_sweep_done", 32'(b0.sweep_done), 32'h0);
    #9;
    rst = 1'b0;
    tick();

    // ramp, wrap, offset and clear vectors
    for (int i = 0; i < 26; i++) begin
      b0.en        = vecs[i].en;
      b0.phase_clr = vecs[i].clr;
      b0.ftw_load  = vecs[i].fl;
      b0.ftw_in    = vecs[i].ftw;
      b0.poff_load = vecs[i].pl;
      b0.poff_in   = vecs[i].poff;
      tick();
      chk($sformatf("vec%0d_phase_out", i), 32'(b0.phase_out), 32'(vecs[i].e_po));
      chk($sformatf("vec%0d_phase_valid", i), 32'(b0.phase_valid), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_wrap", i), 32'(b0.wrap), 32'(vecs[i].e_wrap));
      chk($sformatf("vec%0d_acc", i), 32'(dut0.acc), 32'(vecs[i].e_acc));
    end
    idle();

    // sweep setup: clear acc, ftw=0x100, step=0x100, limit=0x400
    b0.phase_clr   = 1'b1;
    b0.ftw_load    = 1'b1;
    b0.ftw_in      = 24'h000100;
    b0.sweep_step  = 24'h000100;
    b0.sweep_limit = 24'h000400;
    tick();
    idle();
    chk_sweep("setup", 24'h000100, 1'b0, 1'b0);

    b0.en          = 1'b1;
    b0.sweep_start = 1'b1;
    tick();
    b0.sweep_start = 1'b0;
    chk_sweep("start", 24'h000100, 1'b1, 1'b0);
    chk_sweep1("start", 24'h000100, 1'b1, 1'b0);
    tick();
    chk_sweep("step1", 24'h000200, 1'b1, 1'b0);
    chk_sweep1("step1", 24'h000200, 1'b1, 1'b0);
    tick();
    chk_sweep("step2", 24'h000300, 1'b1, 1'b0);
    chk_sweep1("step2", 24'h000300, 1'b1, 1'b0);
    tick();
    chk_sweep("limit", 24'h000400, 1'b0, 1'b1);
    chk_sweep1("limit", 24'h000100, 1'b1, 1'b1);
    chk("limit_acc1", 32'(dut1.acc), 32'h000700);
    tick();
    chk_sweep("hold", 24'h000400, 1'b0, 1'b0);
    chk_sweep1("rewrap", 24'h000200, 1'b1, 1'b0);

    // ftw_load is ignored once the sweep engine owns ftw_reg
    b0.ftw_load = 1'b1;
    b0.ftw_in   = 24'h000050;
    tick();
    b0.ftw_load = 1'b0;
    chk_sweep("hold_load", 24'h000400, 1'b0, 1'b0);
    chk_sweep1("sweep_load", 24'h000300, 1'b1, 1'b0);
    chk("pre_freeze_acc1", 32'(dut1.acc), 32'h000A00);
    chk("pre_freeze_po1", 32'(b1.phase_out), 32'h0001);

    // en low freezes the wrapping sweep and the accumulator
    b0.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("freeze%0d_ftw1", k), 32'(dut1.ftw_reg), 32'h000300);
      chk($sformatf("freeze%0d_acc1", k), 32'(dut1.acc), 32'h000A00);
      chk($sformatf("freeze%0d_po1", k), 32'(b1.phase_out), 32'h0001);
      chk($sformatf("freeze%0d_vld1", k), 32'(b1.phase_valid), 32'h0);
      chk($sformatf("freeze%0d_wrap1", k), 32'(b1.wrap), 32'h0);
    end
    b0.en = 1'b1;
    tick();
    chk_sweep1("resume", 24'h000100, 1'b1, 1'b1);
    chk("resume_acc1", 32'(dut1.acc), 32'h000D00);

    // abort keeps the current ftw
    b0.sweep_abort = 1'b1;
    tick();
    b0.sweep_abort = 1'b0;
    chk_sweep("abort", 24'h000400, 1'b0, 1'b0);
    chk_sweep1("abort", 24'h000100, 1'b0, 1'b0);

    // abort beats start in SWEEP (dut0 would otherwise hit the limit)
    b0.sweep_start = 1'b1;
    tick();
    chk_sweep("restart", 24'h000400, 1'b1, 1'b0);
    b0.sweep_abort = 1'b1;
    tick();
    b0.sweep_start = 1'b0;
    b0.sweep_abort = 1'b0;
    chk_sweep("abort_wins", 24'h000400, 1'b0, 1'b0);
    chk_sweep1("abort_wins", 24'h000100, 1'b0, 1'b0);

    // load with start sets the base; from HOLD, start reloads the base
    b0.ftw_load    = 1'b1;
    b0.ftw_in      = 24'h000380;
    b0.sweep_start = 1'b1;
    tick();
    b0.ftw_load    = 1'b0;
    b0.sweep_start = 1'b0;
    chk_sweep("load_start", 24'h000380, 1'b1, 1'b0);
    tick();
    chk_sweep("first_hit", 24'h000400, 1'b0, 1'b1);
    chk_sweep1("first_hit", 24'h000380, 1'b1, 1'b1);
    b0.sweep_start = 1'b1;
    tick();
    b0.sweep_start = 1'b0;
    chk_sweep("hold_restart", 24'h000380, 1'b1, 1'b0);
    tick();
    chk_sweep("hold_rehit", 24'h000400, 1'b0, 1'b1);

    // asynchronous reset between edges mid-sweep
    #2;
    rst = 1'b1;
    #1;
    chk("arst_po0", 32'(b0.phase_out), 32'h0);
    chk("arst_vld0", 32'(b0.phase_valid), 32'h0);
    chk("arst_done0", 32'(b0.sweep_done), 32'h0);
    chk("arst_po1", 32'(b1.phase_out), 32'h0);
    chk("arst_vld1", 32'(b1.phase_valid), 32'h0);
    chk("arst_wrap1", 32'(b1.wrap), 32'h0);
    chk("arst_sweeping1", 32'(b1.sweeping), 32'h0);
    chk("arst_done1", 32'(b1.sweep_done), 32'h0);
    chk("arst_ftw1", 32'(dut1.ftw_reg), 32'h0);
    chk("arst_acc1", 32'(dut1.acc), 32'h0);
    #3;
    rst = 1'b0;
    b0.en = 1'b0;
    tick();
    chk_sweep("post_rst", 24'h000000, 1'b0, 1'b0);
    chk_sweep1("post_rst", 24'h000000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
